grover_iter_ctrl: RTL and testbench
===================================

Name: grover_iter_ctrl

Overview:
- Sequential driver for the combinational inversion-about-mean (diffusion) block.
- Holds an 8-entry amplitude register file and initialises it to a uniform superposition.
- Each Grover iteration applies the oracle (sign flip of the marked index), presents the vector to the diffusion block, and captures its outputs.
- After the requested number of iterations, scans for the largest amplitude and reports it. This is the initiator/driving end of the diffusion block's i0..i7 / o0..o7 interface.

Parameters:
WIDTH, 8, amplitude width; signed two's complement on every amplitude port.
A_INIT, 16, initial amplitude loaded into all 8 entries.
DM_LAT, 1, cycles to wait between driving dm_i* and capturing dm_o*; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
target  in  3  marked index; latched when start is accepted.
iters  in  4  iteration count; latched when start is accepted; 0 is legal.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse in the DONE state.
result_idx  out  3  index of the maximum amplitude; held until the next start.
result_amp  out  WIDTH  value of the maximum amplitude; held until the next start.
dm_i0..dm_i7  out  WIDTH each  registered vector driven to the diffusion block.
dm_o0..dm_o7  in  WIDTH each  diffusion result, o_k = 2*mean - i_k with mean = floor(sum/8).

Behaviour:
- Reset (asynchronous, any state, including mid-iteration):
  - state = IDLE.
  - busy, done, result_idx, result_amp, all dm_i*, all amplitude registers and all counters = 0.
- IDLE:
  - start=1 latches target and iters, clears the iteration counter, goes to LOAD.
  - start is ignored in all other states.
- LOAD (1 cycle): all amp[k] <= A_INIT. Goes to SCAN if latched iters == 0, else to ORACLE.
- ORACLE (1 cycle):
  - amp[target] <= -amp[target]; all other entries unchanged.
  - Negating -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
- DRIVE (DM_LAT cycles):
  - On entry, dm_ik <= amp[k] for all k.
  - dm_i* hold their value in every other state; they change only on entry to DRIVE.
  - A wait counter runs DM_LAT cycles, then the FSM goes to CAPTURE.
- CAPTURE (1 cycle):
  - amp[k] <= dm_ok for all k, with no saturation or rescale.
  - Iteration counter increments. If the new count == latched iters, go to SCAN; else go to ORACLE.
- SCAN (8 cycles, index 0..7 ascending):
  - Signed comparison with strict greater-than, so ties resolve to the lowest index.
  - Best value starts from amp[0].
- DONE (1 cycle):
  - result_idx and result_amp update, done=1, then return to IDLE.
  - busy drops in the cycle after done.
- Latency: done is high starting 9 + iters*(2+DM_LAT) rising edges after the edge that sampled start.
  - Example: 15 edges for iters=2, DM_LAT=1.
- A start asserted in the same cycle as done is ignored. start is accepted from the following (IDLE) cycle.
- The amplitude register file is internal only; the block has no other outputs.

Test Plan:
1. Reset then idle, with start held low for 20 cycles -> all outputs stay 0 and busy stays 0.
2. target=5, iters=1, DM_LAT=1, bench instantiates the diffusion block -> after iteration 1, amp[5]=40 and others=8. done is high 12 edges after start with result_idx=5, result_amp=40.
3. target=2, iters=2 -> iteration 2 gives amp[2]=44, others=-4. done after 15 edges with result_idx=2, result_amp=44 (= 0x2C). A bench probe of dm_i* during the second DRIVE shows -40 at index 2 and 8 elsewhere.
4. iters=0, target=6 -> no dm_i change (all 0), done after 9 edges, result_idx=0, result_amp=16 (tie resolves to the lowest index).
5. Assert rst for 1 cycle during the second DRIVE of a target=3, iters=2 run -> all outputs clear immediately. A new start with target=1, iters=2 then gives result_idx=1, result_amp=44.
6. Assert start while busy, with a different target -> the request is ignored and results match the original target. Also: negating -128 (preload A_INIT=-128 variant) -> oracle entry becomes 127.

Source files
------------

// File: rtl/grover_iter_ctrl_if.sv
// Control handshake, result and diffusion-block vector signals of grover_iter_ctrl.
interface grover_iter_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic                    start;
    logic [2:0]              target;
    logic [3:0]              iters;
    logic                    busy;
    logic                    done;
    logic [2:0]              result_idx;
    logic signed [WIDTH-1:0] result_amp;
    logic signed [WIDTH-1:0] dm_i0, dm_i1, dm_i2, dm_i3, dm_i4, dm_i5, dm_i6, dm_i7;
    logic signed [WIDTH-1:0] dm_o0, dm_o1, dm_o2, dm_o3, dm_o4, dm_o5, dm_o6, dm_o7;

    // Controller side: takes requests and diffusion results, drives status and vector
    modport master (
        input  start, target, iters,
        input  dm_o0, dm_o1, dm_o2, dm_o3, dm_o4, dm_o5, dm_o6, dm_o7,
        output busy, done, result_idx, result_amp,
        output dm_i0, dm_i1, dm_i2, dm_i3, dm_i4, dm_i5, dm_i6, dm_i7
    );

    // Environment side: issues requests and hosts the diffusion block
    modport slave (
        output start, target, iters,
        output dm_o0, dm_o1, dm_o2, dm_o3, dm_o4, dm_o5, dm_o6, dm_o7,
        input  busy, done, result_idx, result_amp,
        input  dm_i0, dm_i1, dm_i2, dm_i3, dm_i4, dm_i5, dm_i6, dm_i7
    );
endinterface

// File: rtl/grover_iter_ctrl.sv
// Grover iteration sequencer: uniform load, oracle sign flip, external diffusion
// round trip per iteration, then an ascending max scan over the 8 amplitudes.
module grover_iter_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int          A_INIT = 16,
    parameter int unsigned DM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    grover_iter_ctrl_if.master bus
);
    localparam int unsigned N      = 8;
    localparam int unsigned WAIT_W = 4;
    localparam logic signed [WIDTH-1:0] AMP_INIT = WIDTH'(A_INIT);
    localparam logic signed [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WAIT_W-1:0]       WAIT_END = WAIT_W'(DM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, ORACLE, DRIVE, CAPTURE, SCAN, DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]              tgt;
    logic [3:0]              iters_q;
    logic [3:0]              iter_cnt;
    logic [3:0]              iter_next;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [2:0]              scan_idx;
    logic [2:0]              best_idx;
    logic signed [WIDTH-1:0] best_amp;
    logic signed [WIDTH-1:0] amp      [N];
    logic signed [WIDTH-1:0] dm_i_q   [N];
    logic signed [WIDTH-1:0] dm_o     [N];
    logic signed [WIDTH-1:0] oracle_v [N];
    logic signed [WIDTH-1:0] scan_amp;
    logic                    take;
    logic [2:0]              sel_idx;
    logic signed [WIDTH-1:0] sel_amp;
    logic                    busy_q;
    logic                    done_q;
    logic [2:0]              result_idx_q;
    logic signed [WIDTH-1:0] result_amp_q;

    // Diffusion-block results gathered into an array
    always_comb begin
        dm_o[0] = bus.dm_o0;
        dm_o[1] = bus.dm_o1;
        dm_o[2] = bus.dm_o2;
        dm_o[3] = bus.dm_o3;
        dm_o[4] = bus.dm_o4;
        dm_o[5] = bus.dm_o5;
        dm_o[6] = bus.dm_o6;
        dm_o[7] = bus.dm_o7;
    end

    // Oracle vector: marked entry negated, the most negative value saturates
    always_comb begin
        for (int k = 0; k < N; k++) begin
            oracle_v[k] = amp[k];
        end
        oracle_v[tgt] = (amp[tgt] == SMIN) ? SMAX : -amp[tgt];
    end

    // Scan step: first entry seeds the best, later ones must be strictly greater
    always_comb begin
        scan_amp = amp[scan_idx];
        take     = (scan_idx == 3'd0) || (scan_amp > best_amp);
        sel_idx  = take ? scan_idx : best_idx;
        sel_amp  = take ? scan_amp : best_amp;
    end

    assign iter_next = iter_cnt + 4'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    state_next = (iters_q == 4'd0) ? SCAN : ORACLE;
            ORACLE:  state_next = DRIVE;
            DRIVE:   if (wait_cnt == WAIT_END) state_next = CAPTURE;
            CAPTURE: state_next = (iter_next == iters_q) ? SCAN : ORACLE;
            SCAN:    if (scan_idx == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt          <= 3'd0;
            iters_q      <= 4'd0;
            iter_cnt     <= 4'd0;
            wait_cnt     <= '0;
            scan_idx     <= 3'd0;
            best_idx     <= 3'd0;
            best_amp     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_idx_q <= 3'd0;
            result_amp_q <= '0;
            for (int k = 0; k < N; k++) begin
                amp[k]    <= '0;
                dm_i_q[k] <= '0;
            end
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt      <= bus.target;
                        iters_q  <= bus.iters;
                        iter_cnt <= 4'd0;
                    end
                end
                LOAD: begin
                    for (int k = 0; k < N; k++) begin
                        amp[k] <= AMP_INIT;
                    end
                    scan_idx <= 3'd0;
                end
                ORACLE: begin
                    for (int k = 0; k < N; k++) begin
                        amp[k]    <= oracle_v[k];
                        dm_i_q[k] <= oracle_v[k];
                    end
                    wait_cnt <= '0;
                end
                DRIVE: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                CAPTURE: begin
                    for (int k = 0; k < N; k++) begin
                        amp[k] <= dm_o[k];
                    end
                    iter_cnt <= iter_next;
                    scan_idx <= 3'd0;
                end
                SCAN: begin
                    scan_idx <= scan_idx + 3'd1;
                    best_idx <= sel_idx;
                    best_amp <= sel_amp;
                    if (scan_idx == 3'd7) begin
                        result_idx_q <= sel_idx;
                        result_amp_q <= sel_amp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result_idx = result_idx_q;
    assign bus.result_amp = result_amp_q;
    assign bus.dm_i0      = dm_i_q[0];
    assign bus.dm_i1      = dm_i_q[1];
    assign bus.dm_i2      = dm_i_q[2];
    assign bus.dm_i3      = dm_i_q[3];
    assign bus.dm_i4      = dm_i_q[4];
    assign bus.dm_i5      = dm_i_q[5];
    assign bus.dm_i6      = dm_i_q[6];
    assign bus.dm_i7      = dm_i_q[7];
endmodule

// File: tb/tb_grover_iter_ctrl.sv
// Bench for grover_iter_ctrl: two instances (A_INIT 16 / DM_LAT 1 and
// A_INIT -128 / DM_LAT 3), each with a behavioural diffusion block.
module tb_grover_iter_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    grover_iter_ctrl_if #(.WIDTH(W)) if0 ();
    grover_iter_ctrl_if #(.WIDTH(W)) if1 ();

    grover_iter_ctrl #(.WIDTH(W), .A_INIT(16), .DM_LAT(1)) dut0 (
        .clk(clk), .rst(rst0), .bus(if0)
    );
    grover_iter_ctrl #(.WIDTH(W), .A_INIT(-128), .DM_LAT(3)) dut1 (
        .clk(clk), .rst(rst1), .bus(if1)
    );

    int checks = 0;
    int errors = 0;
    int probe_v[8];

    function automatic int floor8(int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    function automatic int wrap8(int v);
        logic signed [7:0] b;
        b = 8'(v);
        return int'(b);
    endfunction

    function automatic logic signed [7:0] diff(int s, int x);
        return 8'(2 * floor8(s) - x);
    endfunction

    // Diffusion blocks: o_k = 2*floor(sum/8) - i_k, truncated to the port width
    int sum0, sum1;
    assign sum0 = int'(if0.dm_i0) + int'(if0.dm_i1) + int'(if0.dm_i2) + int'(if0.dm_i3)
                + int'(if0.dm_i4) + int'(if0.dm_i5) + int'(if0.dm_i6) + int'(if0.dm_i7);
    assign sum1 = int'(if1.dm_i0) + int'(if1.dm_i1) + int'(if1.dm_i2) + int'(if1.dm_i3)
                + int'(if1.dm_i4) + int'(if1.dm_i5) + int'(if1.dm_i6) + int'(if1.dm_i7);
    assign if0.dm_o0 = diff(sum0, int'(if0.dm_i0));
    assign if0.dm_o1 = diff(sum0, int'(if0.dm_i1));
    assign if0.dm_o2 = diff(sum0, int'(if0.dm_i2));
    assign if0.dm_o3 = diff(sum0, int'(if0.dm_i3));
    assign if0.dm_o4 = diff(sum0, int'(if0.dm_i4));
    assign if0.dm_o5 = diff(sum0, int'(if0.dm_i5));
    assign if0.dm_o6 = diff(sum0, int'(if0.dm_i6));
    assign if0.dm_o7 = diff(sum0, int'(if0.dm_i7));
    assign if1.dm_o0 = diff(sum1, int'(if1.dm_i0));
    assign if1.dm_o1 = diff(sum1, int'(if1.dm_i1));
    assign if1.dm_o2 = diff(sum1, int'(if1.dm_i2));
    assign if1.dm_o3 = diff(sum1, int'(if1.dm_i3));
    assign if1.dm_o4 = diff(sum1, int'(if1.dm_i4));
    assign if1.dm_o5 = diff(sum1, int'(if1.dm_i5));
    assign if1.dm_o6 = diff(sum1, int'(if1.dm_i6));
    assign if1.dm_o7 = diff(sum1, int'(if1.dm_i7));

    function automatic int get_dmi(int d, int k);
        if (d == 0) begin
            case (k)
                0: return int'(if0.dm_i0);  1: return int'(if0.dm_i1);
                2: return int'(if0.dm_i2);  3: return int'(if0.dm_i3);
                4: return int'(if0.dm_i4);  5: return int'(if0.dm_i5);
                6: return int'(if0.dm_i6);  default: return int'(if0.dm_i7);
            endcase
        end
        case (k)
            0: return int'(if1.dm_i0);  1: return int'(if1.dm_i1);
            2: return int'(if1.dm_i2);  3: return int'(if1.dm_i3);
            4: return int'(if1.dm_i4);  5: return int'(if1.dm_i5);
            6: return int'(if1.dm_i6);  default: return int'(if1.dm_i7);
        endcase
    endfunction

    function automatic int get_busy(int d);
        return (d == 0) ? int'(if0.busy) : int'(if1.busy);
    endfunction
    function automatic int get_done(int d);
        return (d == 0) ? int'(if0.done) : int'(if1.done);
    endfunction
    function automatic int get_idx(int d);
        return (d == 0) ? int'(if0.result_idx) : int'(if1.result_idx);
    endfunction
    function automatic int get_amp(int d);
        return (d == 0) ? int'(if0.result_amp) : int'(if1.result_amp);
    endfunction

    // OR of every output of instance 0, used for all-zero checks
    function automatic int any_out0();
        int acc;
        acc = int'(if0.busy) | int'(if0.done) | int'(if0.result_idx) | int'(if0.result_amp);
        for (int k = 0; k < 8; k++) acc = acc | get_dmi(0, k);
        return acc;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic s, input int t, input int n);
        if (d == 0) begin
            if0.start = s; if0.target = 3'(t); if0.iters = 4'(n);
        end else begin
            if1.start = s; if1.target = 3'(t); if1.iters = 4'(n);
        end
    endtask

    // Reference: Grover iterations over an 8-entry int array, then argmax (lowest index on ties)
    task automatic ref_run(input int a_init, input int t, input int n,
                           output int idx, output int amp_o);
        int a[8];
        int s;
        for (int k = 0; k < 8; k++) a[k] = a_init;
        for (int it = 0; it < n; it++) begin
            a[t] = (a[t] == -128) ? 127 : -a[t];
            s = 0;
            for (int k = 0; k < 8; k++) s += a[k];
            for (int k = 0; k < 8; k++) a[k] = wrap8(2 * floor8(s) - a[k]);
        end
        idx = 0;
        amp_o = a[0];
        for (int k = 1; k < 8; k++) if (a[k] > amp_o) begin idx = k; amp_o = a[k]; end
    endtask

    // One start/done transaction; latency counted in edges after the sampling edge
    task automatic run(input int d, input int t, input int n, input int probe_edge,
                       input int intr_edge, input int intr_t,
                       output int lat, output int idx, output int amp_o);
        lat = -1;
        @(negedge clk);
        set_in(d, 1'b1, t, n);
        @(posedge clk);
        #1;
        set_in(d, 1'b0, t, n);
        chk("busy_after_start", get_busy(d), 1);
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk);
            #1;
            if (e == intr_edge) set_in(d, 1'b1, intr_t, n);
            if (e == intr_edge + 1) set_in(d, 1'b0, t, n);
            if (e == probe_edge) for (int k = 0; k < 8; k++) probe_v[k] = get_dmi(d, k);
            if (get_done(d) == 1) begin
                lat = e;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
        idx = get_idx(d);
        amp_o = get_amp(d);
        // start during the done cycle must be ignored
        set_in(d, 1'b1, 7, 3);
        @(posedge clk);
        #1;
        set_in(d, 1'b0, 7, 3);
        chk("busy_drop_after_done", get_busy(d), 0);
        chk("done_one_cycle", get_done(d), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("start_in_done_ignored", get_busy(d), 0);
    endtask

    typedef struct {
        int target;
        int iters;
        int probe;
        int exp_idx;
        int exp_amp;
        int exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idx, amp_o, ridx, ramp, acc, t, n;

        vecs[0] = '{target: 5, iters: 1, probe: 0, exp_idx: 5, exp_amp: 40, exp_lat: 12};
        vecs[1] = '{target: 2, iters: 2, probe: 1, exp_idx: 2, exp_amp: 44, exp_lat: 15};
        vecs[2] = '{target: 0, iters: 3, probe: 0, exp_idx: 0, exp_amp: 26, exp_lat: 18};
        vecs[3] = '{target: 7, iters: 2, probe: 1, exp_idx: 7, exp_amp: 44, exp_lat: 15};

        set_in(0, 1'b0, 0, 0);
        set_in(1, 1'b0, 0, 0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", any_out0(), 0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Idle with start low
        acc = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            acc = acc | any_out0();
        end
        chk("idle_quiet", acc, 0);

        // iters = 0: no diffusion traffic, tie resolves to index 0
        run(0, 6, 0, -1, -1, 0, lat, idx, amp_o);
        chk("zero_iter_latency", lat, 9);
        chk("zero_iter_idx", idx, 0);
        chk("zero_iter_amp", amp_o, 16);
        for (int k = 0; k < 8; k++) chk($sformatf("zero_iter_dm_i%0d", k), get_dmi(0, k), 0);

        // Table-driven runs on instance 0
        for (int v = 0; v < 4; v++) begin
            run(0, vecs[v].target, vecs[v].iters, vecs[v].probe ? 5 : -1, -1, 0, lat, idx, amp_o);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("vec%0d_idx", v), idx, vecs[v].exp_idx);
            chk($sformatf("vec%0d_amp", v), amp_o, vecs[v].exp_amp);
            if (vecs[v].probe != 0)
                for (int k = 0; k < 8; k++)
                    chk($sformatf("vec%0d_drive2_dm_i%0d", v, k), probe_v[k],
                        (k == vecs[v].target) ? -40 : 8);
        end

        // Reset asserted in the second DRIVE of a target 3 run
        @(negedge clk);
        set_in(0, 1'b1, 3, 2);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 3, 2);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_run_busy", get_busy(0), 1);
        rst0 = 1'b1;
        #1;
        chk("mid_run_reset_clear", any_out0(), 0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        chk("after_reset_clear", any_out0(), 0);
        run(0, 1, 2, -1, -1, 0, lat, idx, amp_o);
        chk("post_reset_latency", lat, 15);
        chk("post_reset_idx", idx, 1);
        chk("post_reset_amp", amp_o, 44);

        // start while busy with a different target is ignored
        run(0, 4, 2, -1, 2, 7, lat, idx, amp_o);
        chk("busy_start_latency", lat, 15);
        chk("busy_start_idx", idx, 4);
        chk("busy_start_amp", amp_o, 44);

        // Randomized runs on instance 0 against the reference
        for (int r = 0; r < 16; r++) begin
            t = $urandom_range(0, 7);
            n = $urandom_range(0, 6);
            ref_run(16, t, n, ridx, ramp);
            run(0, t, n, -1, -1, 0, lat, idx, amp_o);
            chk($sformatf("rand%0d_t%0d_n%0d_latency", r, t, n), lat, 9 + 3 * n);
            chk($sformatf("rand%0d_t%0d_n%0d_idx", r, t, n), idx, ridx);
            chk($sformatf("rand%0d_t%0d_n%0d_amp", r, t, n), amp_o, ramp);
        end

        // Instance 1: negating -128 saturates to 127, DM_LAT = 3
        run(1, 3, 1, 2, -1, 0, lat, idx, amp_o);
        ref_run(-128, 3, 1, ridx, ramp);
        for (int k = 0; k < 8; k++)
            chk($sformatf("sat_dm_i%0d", k), probe_v[k], (k == 3) ? 127 : -128);
        chk("sat_latency", lat, 14);
        chk("sat_idx", idx, ridx);
        chk("sat_amp", amp_o, ramp);

        for (int r = 0; r < 4; r++) begin
            t = $urandom_range(0, 7);
            n = $urandom_range(0, 5);
            ref_run(-128, t, n, ridx, ramp);
            run(1, t, n, -1, -1, 0, lat, idx, amp_o);
            chk($sformatf("sat_rand%0d_latency", r), lat, 9 + 5 * n);
            chk($sformatf("sat_rand%0d_idx", r), idx, ridx);
            chk($sformatf("sat_rand%0d_amp", r), amp_o, ramp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
